// File: rtl/mestre_memoria_dados.sv
// Data-memory master: serialises LOAD, STORE and byte-wise COPY requests
// onto a single-port memory with one-cycle synchronous read latency.
module mestre_memoria_dados #(
   parameter int LARGURA_DADO = 8,
   parameter int LARGURA_END  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    reqValido,
   output logic                    reqPronto,
   input  logic [1:0]              operacao,
   input  logic [LARGURA_END-1:0]  enderecoA,
   input  logic [LARGURA_END-1:0]  enderecoB,
   input  logic [LARGURA_DADO-1:0] dadoEscrita,
   input  logic [7:0]              tamanho,
   output logic                    respValida,
   output logic [LARGURA_DADO-1:0] dadoLido,
   output logic                    erro,
   output logic                    ocupado,
   output logic                    writeEnable,
   output logic [LARGURA_END-1:0]  endereco,
   output logic [LARGURA_DADO-1:0] dadoEntrada,
   input  logic [LARGURA_DADO-1:0] dadoSaida
);

   typedef enum logic [2:0] {OCIOSO, LEITURA, CAPTURA, ESCRITA, RESPOSTA} estado_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b10;

   estado_t                estado, proxEstado;
   logic [1:0]             opReg;
   logic [LARGURA_END-1:0] baseA, baseB;
   logic [7:0]             tamReg, indice, indiceProx;
   logic                   ultimoByte;

   assign indiceProx  = indice + 8'd1;
   assign ultimoByte  = (indiceProx == tamReg);

   assign reqPronto   = (estado == OCIOSO);
   assign ocupado     = (estado != OCIOSO);
   assign writeEnable = (estado == ESCRITA);
   assign respValida  = (estado == RESPOSTA);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) estado <= OCIOSO;
      else       estado <= proxEstado;
   end

   always_comb begin
      proxEstado = estado;
      case (estado)
         OCIOSO:
            if (reqValido) begin
               case (operacao)
                  OP_LOAD:  proxEstado = LEITURA;
                  OP_STORE: proxEstado = ESCRITA;
                  OP_COPY:  proxEstado = (tamanho == 8'd0) ? RESPOSTA : LEITURA;
                  default:  proxEstado = RESPOSTA;
               endcase
            end
         LEITURA:  proxEstado = CAPTURA;
         CAPTURA:  proxEstado = (opReg == OP_COPY) ? ESCRITA : RESPOSTA;
         ESCRITA:  proxEstado = (opReg == OP_COPY && !ultimoByte) ? LEITURA : RESPOSTA;
         RESPOSTA: proxEstado = OCIOSO;
         default:  proxEstado = OCIOSO;
      endcase
   end

   // Address/data registers only move on active transitions, so the memory
   // port holds its last value while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opReg       <= '0;
         baseA       <= '0;
         baseB       <= '0;
         tamReg      <= '0;
         indice      <= '0;
         erro        <= 1'b0;
         dadoLido    <= '0;
         endereco    <= '0;
         dadoEntrada <= '0;
      end else begin
         case (estado)
            OCIOSO:
               if (reqValido) begin
                  opReg  <= operacao;
                  baseA  <= enderecoA;
                  baseB  <= enderecoB;
                  tamReg <= tamanho;
                  indice <= '0;
                  erro   <= (operacao == 2'b11);
                  if (operacao == OP_LOAD || operacao == OP_STORE ||
                      (operacao == OP_COPY && tamanho != 8'd0))
                     endereco <= enderecoA;
                  if (operacao == OP_STORE)
                     dadoEntrada <= dadoEscrita;
               end
            CAPTURA:
               if (opReg == OP_COPY) begin
                  dadoEntrada <= dadoSaida;
                  endereco    <= baseB + LARGURA_END'(indice);
               end else begin
                  dadoLido <= dadoSaida;
               end
            ESCRITA:
               if (opReg == OP_COPY) begin
                  if (ultimoByte) begin
                     dadoLido <= dadoEntrada;
                  end else begin
                     indice   <= indiceProx;
                     endereco <= baseA + LARGURA_END'(indiceProx);
                  end
               end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mestre_memoria_dados.sv
module tb_mestre_memoria_dados;

  logic       clk = 1'b0;
  logic       reset;
  logic       reqValido;
  logic       reqPronto;
  logic [1:0] operacao;
  logic [7:0] enderecoA, enderecoB, dadoEscrita, tamanho;
  logic       respValida;
  logic [7:0] dadoLido;
  logic       erro, ocupado, writeEnable;
  logic [7:0] endereco, dadoEntrada;
  logic [7:0] dadoSaida;

  logic [7:0] mem [256];

  int         vectors = 0;
  int         miscompares = 0;

  int         respCyc, nWr;
  int         wrCyc  [8];
  logic [7:0] wrAddr [8];
  logic [7:0] wrData [8];
  logic [7:0] addrAt [64];
  logic       erroSeen;

  mestre_memoria_dados #(.LARGURA_DADO(8), .LARGURA_END(8)) dut (
    .clk(clk), .reset(reset), .reqValido(reqValido), .reqPronto(reqPronto),
    .operacao(operacao), .enderecoA(enderecoA), .enderecoB(enderecoB),
    .dadoEscrita(dadoEscrita), .tamanho(tamanho), .respValida(respValida),
    .dadoLido(dadoLido), .erro(erro), .ocupado(ocupado),
    .writeEnable(writeEnable), .endereco(endereco),
    .dadoEntrada(dadoEntrada), .dadoSaida(dadoSaida)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (writeEnable) mem[endereco] <= dadoEntrada;
    dadoSaida <= mem[endereco];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reqRun(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic [7:0] t,
                        input int expResp, input int expWr);
    int cyc;
    operacao = op; enderecoA = a; enderecoB = b; dadoEscrita = d; tamanho = t;
    reqValido = 1'b1;
    @(posedge clk);
    cyc = 0; respCyc = -1; nWr = 0; erroSeen = 1'b0;
    while (respCyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      reqValido = 1'b0; enderecoA = ~a; enderecoB = ~b; dadoEscrita = ~d; operacao = ~op;
      if (cyc < 64) addrAt[cyc] = endereco;
      if (writeEnable && nWr < 8) begin
        wrCyc[nWr] = cyc; wrAddr[nWr] = endereco; wrData[nWr] = dadoEntrada;
        nWr++;
      end
      if (respValida) begin
        respCyc = cyc;
        erroSeen = erro;
      end
    end
    chk("resp_timeout", (respCyc >= 0), 1'b1);
    chk("resp_latency", respCyc, expResp);
    chk("write_count", nWr, expWr);
    @(negedge clk);
    chk("resp_one_cycle", respValida, 1'b0);
    chk("ready_after_resp", reqPronto, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    dadoSaida = 8'h00;
    reqValido = 1'b0; operacao = 2'b00; enderecoA = 8'h00; enderecoB = 8'h00;
    dadoEscrita = 8'h00; tamanho = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_reqPronto", reqPronto, 1'b1);
    chk("rst_respValida", respValida, 1'b0);
    chk("rst_writeEnable", writeEnable, 1'b0);
    chk("rst_endereco", endereco, 8'h00);
    chk("rst_dadoEntrada", dadoEntrada, 8'h00);
    chk("rst_dadoLido", dadoLido, 8'h00);
    chk("rst_erro", erro, 1'b0);
    chk("rst_ocupado", ocupado, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    reqRun(2'b01, 8'h0F, 8'h00, 8'hF0, 8'h00, 2, 1);
    chk("st_wr_cycle", wrCyc[0], 1);
    chk("st_wr_addr", wrAddr[0], 8'h0F);
    chk("st_wr_data", wrData[0], 8'hF0);
    chk("st_erro", erroSeen, 1'b0);
    reqRun(2'b00, 8'h0F, 8'h00, 8'h00, 8'h00, 3, 0);
    chk("ld_0F", dadoLido, 8'hF0);

    reqRun(2'b01, 8'hF0, 8'h00, 8'h0F, 8'h00, 2, 1);
    reqRun(2'b00, 8'h0F, 8'h00, 8'h00, 8'h00, 3, 0);
    chk("alias_ld_0F", dadoLido, 8'hF0);
    reqRun(2'b00, 8'hF0, 8'h00, 8'h00, 8'h00, 3, 0);
    chk("alias_ld_F0", dadoLido, 8'h0F);

    reqRun(2'b01, 8'h0F, 8'h00, 8'hA1, 8'h00, 2, 1);
    reqRun(2'b01, 8'h10, 8'h00, 8'hA2, 8'h00, 2, 1);
    reqRun(2'b01, 8'h11, 8'h00, 8'hA3, 8'h00, 2, 1);
    reqRun(2'b10, 8'h0F, 8'h20, 8'h00, 8'd3, 10, 3);
    chk("cp_wr0_cyc", wrCyc[0], 3);
    chk("cp_wr1_cyc", wrCyc[1], 6);
    chk("cp_wr2_cyc", wrCyc[2], 9);
    chk("cp_wr0_addr", wrAddr[0], 8'h20);
    chk("cp_wr1_addr", wrAddr[1], 8'h21);
    chk("cp_wr2_addr", wrAddr[2], 8'h22);
    chk("cp_wr0_data", wrData[0], 8'hA1);
    chk("cp_wr2_data", wrData[2], 8'hA3);
    chk("cp_dadoLido", dadoLido, 8'hA3);
    reqRun(2'b00, 8'h20, 8'h00, 8'h00, 8'h00, 3, 0);
    chk("cp_ld_20", dadoLido, 8'hA1);
    reqRun(2'b00, 8'h21, 8'h00, 8'h00, 8'h00, 3, 0);
    chk("cp_ld_21", dadoLido, 8'hA2);
    reqRun(2'b00, 8'h22, 8'h00, 8'h00, 8'h00, 3, 0);
    chk("cp_ld_22", dadoLido, 8'hA3);

    reqRun(2'b01, 8'hFE, 8'h00, 8'hB1, 8'h00, 2, 1);
    reqRun(2'b01, 8'hFF, 8'h00, 8'hB2, 8'h00, 2, 1);
    reqRun(2'b01, 8'h00, 8'h00, 8'hB3, 8'h00, 2, 1);
    reqRun(2'b10, 8'hFE, 8'h10, 8'h00, 8'd3, 10, 3);
    chk("wrap_rd0", addrAt[1], 8'hFE);
    chk("wrap_rd1", addrAt[4], 8'hFF);
    chk("wrap_rd2", addrAt[7], 8'h00);
    chk("wrap_wr0_addr", wrAddr[0], 8'h10);
    chk("wrap_wr2_addr", wrAddr[2], 8'h12);
    chk("wrap_wr2_data", wrData[2], 8'hB3);
    reqRun(2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 3, 0);
    chk("wrap_ld_10", dadoLido, 8'hB1);
    reqRun(2'b00, 8'h12, 8'h00, 8'h00, 8'h00, 3, 0);
    chk("wrap_ld_12", dadoLido, 8'hB3);

    reqRun(2'b11, 8'h33, 8'h44, 8'h55, 8'd4, 1, 0);
    chk("rsv_erro", erroSeen, 1'b1);
    chk("rsv_dadoLido", dadoLido, 8'hB3);
    reqRun(2'b10, 8'h33, 8'h44, 8'h00, 8'd0, 1, 0);
    chk("cp0_erro", erroSeen, 1'b0);
    chk("cp0_dadoLido", dadoLido, 8'hB3);

    reqRun(2'b01, 8'h30, 8'h00, 8'hC1, 8'h00, 2, 1);
    reqRun(2'b01, 8'h31, 8'h00, 8'hC2, 8'h00, 2, 1);
    reqRun(2'b01, 8'h41, 8'h00, 8'h55, 8'h00, 2, 1);
    operacao = 2'b10; enderecoA = 8'h30; enderecoB = 8'h40; tamanho = 8'd3;
    reqValido = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValido = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_writeEnable", writeEnable, 1'b0);
    chk("mid_rst_endereco", endereco, 8'h00);
    chk("mid_rst_dadoLido", dadoLido, 8'h00);
    chk("mid_rst_ocupado", ocupado, 1'b0);
    chk("mid_rst_respValida", respValida, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", reqPronto, 1'b1);
    reqRun(2'b00, 8'h40, 8'h00, 8'h00, 8'h00, 3, 0);
    chk("mid_rst_ld_40", dadoLido, 8'hC1);
    reqRun(2'b00, 8'h41, 8'h00, 8'h00, 8'h00, 3, 0);
    chk("mid_rst_ld_41", dadoLido, 8'h55);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
